// File: rtl/insn_encoder_loader.sv
// insn_encoder_loader: boot/test program loader that sits ahead of fetch.
// Accepts symbolic micro-ops (LW, SW, AND, OR, ADD, SUB) on a valid/ready stream.
// Each legal micro-op is encoded into a 32-bit RV32I word and written into
// instruction memory at sequential word addresses, starting from a programmed
// base address.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start_i             pulse that begins a load session; honoured only in idle
//   base_addr_i         first imem byte address; sampled when start_i is accepted
//   cmd_valid_i         micro-op valid
//   cmd_ready_o         micro-op ready; high only while loading
//   cmd_op_i            opcode: 0=LW 1=SW 2=AND 3=OR 4=ADD 5=SUB; 6 and 7 are illegal
//   cmd_rd_i            destination register
//   cmd_rs1_i           source register 1 / base register
//   cmd_rs2_i           source register 2 / store data register
//   cmd_imm_i           LW/SW offset; ignored for the other opcodes
//   cmd_last_i          marks the final micro-op of the session
//   imem_we_o           registered write strobe
//   imem_addr_o         write byte address
//   imem_wdata_o        encoded instruction
//   busy_o              high whenever the loader is not idle
//   done_o              1-cycle pulse at the end of a session
//   error_o             sticky flag: an illegal op was seen in this session
//   insn_count_o        number of words written in this session (saturating)
module insn_encoder_loader #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [4:0]        cmd_rd_i,
  input  logic [4:0]        cmd_rs1_i,
  input  logic [4:0]        cmd_rs2_i,
  input  logic [11:0]       cmd_imm_i,
  input  logic              cmd_last_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [CNT_W-1:0]  insn_count_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_ptr_q, addr_ptr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                error_q, error_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                beat;
  logic                enc_legal;
  logic [31:0]         enc_word;

  assign beat = cmd_valid_i && (state_q == StLoad);

  // Micro-op to RV32I encoder.
  always_comb begin
    enc_legal = 1'b1;
    enc_word  = 32'h0;
    case (cmd_op_i)
      3'd0: enc_word = {cmd_imm_i, cmd_rs1_i, 3'b010, cmd_rd_i, 7'b0000011};
      3'd1: enc_word = {cmd_imm_i[11:5], cmd_rs2_i, cmd_rs1_i, 3'b010, cmd_imm_i[4:0],
                        7'b0100011};
      3'd2: enc_word = {7'b0000000, cmd_rs2_i, cmd_rs1_i, 3'b111, cmd_rd_i, 7'b0110011};
      3'd3: enc_word = {7'b0000000, cmd_rs2_i, cmd_rs1_i, 3'b110, cmd_rd_i, 7'b0110011};
      3'd4: enc_word = {7'b0000000, cmd_rs2_i, cmd_rs1_i, 3'b000, cmd_rd_i, 7'b0110011};
      3'd5: enc_word = {7'b0100000, cmd_rs2_i, cmd_rs1_i, 3'b000, cmd_rd_i, 7'b0110011};
      default: enc_legal = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    addr_ptr_d = addr_ptr_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    error_d    = error_q;
    cnt_d      = cnt_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d    = StLoad;
          addr_ptr_d = base_addr_i;
          error_d    = 1'b0;
          cnt_d      = '0;
        end
      end
      StLoad: begin
        if (beat) begin
          if (enc_legal) begin
            we_d       = 1'b1;
            addr_d     = addr_ptr_q;
            wdata_d    = enc_word;
            addr_ptr_d = addr_ptr_q + ADDR_W'(4);
            cnt_d      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          end else begin
            error_d = 1'b1;
          end
          // An illegal op carrying last still closes the session.
          if (cmd_last_i) begin
            state_d = StDone;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_ptr_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      error_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_ptr_q <= addr_ptr_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      error_q    <= error_d;
      cnt_q      <= cnt_d;
    end
  end

  assign cmd_ready_o  = (state_q == StLoad);
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign error_o      = error_q;
  assign insn_count_o = cnt_q;

endmodule

// File: tb/tb_insn_encoder_loader.sv
// Directed bench for insn_encoder_loader: hand-encoded RV32I words and addresses.
module tb_insn_encoder_loader;

  localparam logic [2:0] OpLw = 3'd0, OpSw = 3'd1, OpAnd = 3'd2, OpOr = 3'd3,
                         OpAdd = 3'd4, OpSub = 3'd5, OpBad6 = 3'd6, OpBad7 = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic [11:0] cmd_imm;
  logic        cmd_last;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done, error;
  logic [15:0] insn_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  insn_encoder_loader #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_op_i     (cmd_op),
    .cmd_rd_i     (cmd_rd),
    .cmd_rs1_i    (cmd_rs1),
    .cmd_rs2_i    (cmd_rs2),
    .cmd_imm_i    (cmd_imm),
    .cmd_last_i   (cmd_last),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error),
    .insn_count_o (insn_count)
  );

  // Inputs change #1 after a rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] base);
    start     = 1'b1;
    base_addr = base;
    tick();
    start     = 1'b0;
  endtask

  task automatic set_cmd(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [11:0] imm, input logic last);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    cmd_imm   = imm;
    cmd_last  = last;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_count", 32'(insn_count), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  task automatic test_single_add();
    do_start(32'h100);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready", 32'(cmd_ready), 32'd1);
    // start while loading must not restart the session
    start = 1'b1;
    base_addr = 32'h900;
    tick();
    start = 1'b0;
    set_cmd(OpAdd, 5'd3, 5'd1, 5'd2, 12'h0, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk("t1_we", 32'(imem_we), 32'd1);
    chk("t1_addr", imem_addr, 32'h100);
    chk("t1_wdata", imem_wdata, 32'h002081B3);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_count", 32'(insn_count), 32'd1);
    // start coinciding with DONE is dropped
    start = 1'b1;
    base_addr = 32'h500;
    tick();
    start = 1'b0;
    chk("t1_we_off", 32'(imem_we), 32'd0);
    chk("t1_done_off", 32'(done), 32'd0);
    chk("t1_busy_idle", 32'(busy), 32'd0);
    chk("t1_addr_hold", imem_addr, 32'h100);
    tick();
    chk("t1_still_idle", 32'(busy), 32'd0);
  endtask

  task automatic test_back_to_back();
    do_start(32'h0);
    set_cmd(OpSub, 5'd5, 5'd6, 5'd7, 12'h0, 1'b0);
    tick();
    chk("t2_we0", 32'(imem_we), 32'd1);
    chk("t2_addr0", imem_addr, 32'h0);
    chk("t2_wdata0", imem_wdata, 32'h407302B3);
    chk("t2_done0", 32'(done), 32'd0);
    set_cmd(OpLw, 5'd1, 5'd2, 5'd0, 12'd8, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk("t2_we1", 32'(imem_we), 32'd1);
    chk("t2_addr1", imem_addr, 32'h4);
    chk("t2_wdata1", imem_wdata, 32'h00812083);
    chk("t2_count", 32'(insn_count), 32'd2);
    tick();
  endtask

  task automatic test_store();
    do_start(32'h40);
    // rd is unused by SW and must not leak into the word
    set_cmd(OpSw, 5'd31, 5'd4, 5'd3, 12'd12, 1'b0);
    tick();
    chk("t3_wdata0", imem_wdata, 32'h00322623);
    set_cmd(OpSw, 5'd0, 5'd4, 5'd3, 12'hFFC, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk("t3_wdata1", imem_wdata, 32'hFE322E23);
    chk("t3_addr1", imem_addr, 32'h44);
    tick();
  endtask

  task automatic test_or();
    do_start(32'h80);
    set_cmd(OpOr, 5'd10, 5'd11, 5'd12, 12'hABC, 1'b1);
    tick();
    cmd_valid = 1'b0;
    // 0000000 01100 01011 110 01010 0110011
    chk("or_wdata", imem_wdata, 32'h00C5E533);
    tick();
  endtask

  task automatic test_illegal();
    do_start(32'h200);
    set_cmd(OpAdd, 5'd1, 5'd0, 5'd0, 12'h0, 1'b0);
    tick();
    chk("t4_addr0", imem_addr, 32'h200);
    chk("t4_wdata0", imem_wdata, 32'h000000B3);
    set_cmd(OpBad7, 5'd9, 5'd9, 5'd9, 12'h0, 1'b0);
    tick();
    chk("t4_bad_we", 32'(imem_we), 32'd0);
    chk("t4_err", 32'(error), 32'd1);
    chk("t4_addr_hold", imem_addr, 32'h200);
    set_cmd(OpAdd, 5'd2, 5'd0, 5'd0, 12'h0, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk("t4_addr1", imem_addr, 32'h204);
    chk("t4_wdata1", imem_wdata, 32'h00000133);
    chk("t4_count", 32'(insn_count), 32'd2);
    tick();
    chk("t4_err_sticky", 32'(error), 32'd1);
    // illegal op with last still closes the session
    do_start(32'h300);
    chk("t4_err_clr", 32'(error), 32'd0);
    set_cmd(OpBad6, 5'd1, 5'd1, 5'd1, 12'h0, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk("t4b_done", 32'(done), 32'd1);
    chk("t4b_we", 32'(imem_we), 32'd0);
    chk("t4b_err", 32'(error), 32'd1);
    chk("t4b_count", 32'(insn_count), 32'd0);
    tick();
  endtask

  task automatic test_wrap();
    do_start(32'hFFFF_FFFC);
    chk("t5_err_clr", 32'(error), 32'd0);
    set_cmd(OpAnd, 5'd4, 5'd5, 5'd6, 12'h0, 1'b0);
    tick();
    chk("t5_addr0", imem_addr, 32'hFFFF_FFFC);
    chk("t5_wdata0", imem_wdata, 32'h0062F233);
    set_cmd(OpAnd, 5'd4, 5'd5, 5'd6, 12'h0, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk("t5_addr1", imem_addr, 32'h0000_0000);
    chk("t5_we1", 32'(imem_we), 32'd1);
    tick();
  endtask

  task automatic test_reset_mid();
    do_start(32'h1000);
    set_cmd(OpAdd, 5'd3, 5'd1, 5'd2, 12'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_we", 32'(imem_we), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("t6_we_held", 32'(imem_we), 32'd0);
    chk("t6_count", 32'(insn_count), 32'd0);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    do_start(32'h2000);
    chk("t6_restart", 32'(busy), 32'd1);
    set_cmd(OpAdd, 5'd3, 5'd1, 5'd2, 12'h0, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk("t6_addr", imem_addr, 32'h2000);
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = 32'h0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_rd    = 5'd0;
    cmd_rs1   = 5'd0;
    cmd_rs2   = 5'd0;
    cmd_imm   = 12'h0;
    cmd_last  = 1'b0;
    #12;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_single_add();
    test_back_to_back();
    test_store();
    test_or();
    test_illegal();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
